// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared types and helpers for the SPI master transfer sequencer.
package spi_xfer_ctrl_pkg;

  localparam int SPI_BR_WIDTH  = 8;
  localparam int SPI_LEN_WIDTH = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    LEAD,
    TRAIL,
    STORE,
    GAP
  } spi_xfer_state_e;

  typedef struct packed {
    logic                     enable;
    logic                     cpol;
    logic                     cpha;
    logic                     dord;
    logic [SPI_LEN_WIDTH-1:0] datalen;
    logic [SPI_BR_WIDTH-1:0]  br_div;
  } sc2xc_t;

  function automatic logic mux32_1(input logic [31:0] d, input logic [4:0] sel);
    return d[sel];
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// FIFO, configuration and pin bundle between the SPI sequencer and its surroundings.
interface spi_xfer_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8
);
  logic                  enable;
  logic                  cpol;
  logic                  cpha;
  logic                  dord;
  logic [4:0]            datalen;
  logic [DIV_WIDTH-1:0]  br_div;
  logic                  tfifo_empty;
  logic [DATA_WIDTH-1:0] tfifo_rdata;
  logic                  tfifo_ren;
  logic                  rfifo_full;
  logic                  rfifo_wen;
  logic [DATA_WIDTH-1:0] rfifo_wdata;
  logic                  sclk;
  logic                  ss_n;
  logic                  mosi;
  logic                  miso;
  logic                  busy;
  logic                  done;
  logic                  rx_overrun;

  modport master (
    input  enable, cpol, cpha, dord, datalen, br_div,
    input  tfifo_empty, tfifo_rdata, rfifo_full, miso,
    output tfifo_ren, rfifo_wen, rfifo_wdata, sclk, ss_n, mosi, busy, done, rx_overrun
  );

  modport slave (
    output enable, cpol, cpha, dord, datalen, br_div,
    output tfifo_empty, tfifo_rdata, rfifo_full, miso,
    input  tfifo_ren, rfifo_wen, rfifo_wdata, sclk, ss_n, mosi, busy, done, rx_overrun
  );
endinterface

// File: rtl/spi_xfer_ctrl_clk_div.sv
// sclk half-period timer: counts 0..div and ticks on the terminal count.
module spi_xfer_ctrl_clk_div #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] cnt;

  assign tick = !clr && (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_xfer_ctrl.sv
// Master-mode SPI frame sequencer: TX FIFO -> mosi/miso shift -> RX FIFO.
// Define SPI_CONT_XFER_EN to chain queued frames without deasserting ss_n.
module spi_xfer_ctrl
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = SPI_BR_WIDTH
) (
  input  logic             pclk,
  input  logic             preset_n,
  spi_xfer_ctrl_if.master  bus
);
  spi_xfer_state_e         state;
  sc2xc_t                  cfg_in;
  logic                    cpol_q, cpha_q, dord_q;
  logic [4:0]              len_q;
  logic [SPI_BR_WIDTH-1:0] div_q;
  logic [31:0]             tx_reg, rx_reg;
  logic [4:0]              bit_cnt, cur_idx, nxt_idx, first_idx;
  logic                    last_bit, tick, div_clr;
  logic                    sclk_q, ss_n_q, mosi_q, ren_q, wen_q, done_q, ovr_q, busy_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  function automatic logic [4:0] bit_index(input logic dord, input logic [4:0] len,
                                           input logic [4:0] cnt);
    return dord ? cnt : 5'(len - cnt);
  endfunction

  assign cfg_in.enable  = bus.enable;
  assign cfg_in.cpol    = bus.cpol;
  assign cfg_in.cpha    = bus.cpha;
  assign cfg_in.dord    = bus.dord;
  assign cfg_in.datalen = bus.datalen;
  assign cfg_in.br_div  = SPI_BR_WIDTH'(bus.br_div);

  assign last_bit  = (bit_cnt == len_q);
  assign cur_idx   = bit_index(dord_q, len_q, bit_cnt);
  assign nxt_idx   = bit_index(dord_q, len_q, 5'(bit_cnt + 5'd1));
  assign first_idx = cfg_in.dord ? 5'd0 : cfg_in.datalen;
  // Timer only runs in the half-period states so each one starts from zero.
  assign div_clr   = (state == IDLE) || (state == LOAD) || (state == STORE);

  spi_xfer_ctrl_clk_div #(.DIV_WIDTH(SPI_BR_WIDTH)) u_clk_div (
    .clk   (pclk),
    .rst_n (preset_n),
    .clr   (div_clr),
    .div   (div_q),
    .tick  (tick)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state   <= IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      dord_q  <= 1'b0;
      len_q   <= '0;
      div_q   <= '0;
      tx_reg  <= '0;
      rx_reg  <= '0;
      bit_cnt <= '0;
      sclk_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ren_q  <= 1'b0;
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      case (state)
        IDLE: begin
          sclk_q <= cfg_in.cpol;
          ss_n_q <= 1'b1;
          if (cfg_in.enable && !bus.tfifo_empty) begin
            state  <= LOAD;
            ren_q  <= 1'b1;
            ss_n_q <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          tx_reg  <= 32'(bus.tfifo_rdata);
          rx_reg  <= '0;
          bit_cnt <= '0;
          cpol_q  <= cfg_in.cpol;
          cpha_q  <= cfg_in.cpha;
          dord_q  <= cfg_in.dord;
          len_q   <= cfg_in.datalen;
          div_q   <= cfg_in.br_div;
          sclk_q  <= cfg_in.cpol;
          if (!cfg_in.cpha) mosi_q <= mux32_1(32'(bus.tfifo_rdata), first_idx);
          state   <= SETUP;
        end
        SETUP: if (tick) begin
          state  <= LEAD;
          sclk_q <= !cpol_q;
          if (!cpha_q) rx_reg[cur_idx] <= bus.miso;
          else         mosi_q <= mux32_1(tx_reg, cur_idx);
        end
        LEAD: if (tick) begin
          state  <= TRAIL;
          sclk_q <= cpol_q;
          if (cpha_q)         rx_reg[cur_idx] <= bus.miso;
          else if (!last_bit) mosi_q <= mux32_1(tx_reg, nxt_idx);
        end
        TRAIL: if (tick) begin
          if (last_bit) begin
            state  <= STORE;
            done_q <= 1'b1;
            if (bus.rfifo_full) begin
              ovr_q <= 1'b1;
            end else begin
              wen_q   <= 1'b1;
              wdata_q <= DATA_WIDTH'(rx_reg);
            end
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            state   <= LEAD;
            sclk_q  <= !cpol_q;
            if (cpha_q) mosi_q <= mux32_1(tx_reg, nxt_idx);
            else        rx_reg[nxt_idx] <= bus.miso;
          end
        end
        STORE: begin
`ifdef SPI_CONT_XFER_EN
          if (cfg_in.enable && !bus.tfifo_empty) begin
            state <= LOAD;
            ren_q <= 1'b1;
          end else begin
            state  <= GAP;
            ss_n_q <= 1'b1;
          end
`else
          state  <= GAP;
          ss_n_q <= 1'b1;
`endif
        end
        GAP: if (tick) begin
          state  <= IDLE;
          busy_q <= 1'b0;
          sclk_q <= cfg_in.cpol;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tfifo_ren   = ren_q;
  assign bus.rfifo_wen   = wen_q;
  assign bus.rfifo_wdata = wdata_q;
  assign bus.sclk        = sclk_q;
  assign bus.ss_n        = ss_n_q;
  assign bus.mosi        = mosi_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rx_overrun  = ovr_q;
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed self-checking bench for spi_xfer_ctrl with miso looped back to mosi.
module tb_spi_xfer_ctrl;
  logic pclk = 1'b0;
  logic preset_n;
  always #5 pclk = ~pclk;

  spi_xfer_ctrl_if #(.DATA_WIDTH(32), .DIV_WIDTH(8)) ifc ();

  spi_xfer_ctrl #(.DATA_WIDTH(32), .DIV_WIDTH(8)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (ifc)
  );

  logic [31:0] tx_mem [0:7];
  logic [2:0]  tx_wr = '0;
  logic [2:0]  tx_rd = '0;
  logic        pop_pend = 1'b0;

  assign ifc.tfifo_empty = (tx_wr == tx_rd);
  assign ifc.tfifo_rdata = tx_mem[tx_rd];
  assign ifc.miso        = ifc.mosi;

  int          cyc = 0, rise_cnt = 0, ss_rise_cnt = 0;
  int          done_cnt = 0, ren_cnt = 0, wen_cnt = 0, ovr_cnt = 0;
  int          load_cyc = 0, store_cyc = 0, last_rise = 0, rise_per = 0;
  logic [31:0] mosi_log = '0;
  logic        prev_sclk = 1'b0, prev_ss = 1'b1;

  always @(negedge pclk) begin
    cyc = cyc + 1;
    if (pop_pend) tx_rd = tx_rd + 3'd1;
    pop_pend = ifc.tfifo_ren;
    if (ifc.tfifo_ren) begin ren_cnt = ren_cnt + 1; load_cyc = cyc; end
    if (ifc.done) begin done_cnt = done_cnt + 1; store_cyc = cyc; end
    if (ifc.rfifo_wen) wen_cnt = wen_cnt + 1;
    if (ifc.rx_overrun) ovr_cnt = ovr_cnt + 1;
    if (ifc.sclk && !prev_sclk) begin
      rise_cnt  = rise_cnt + 1;
      mosi_log  = {mosi_log[30:0], ifc.mosi};
      rise_per  = cyc - last_rise;
      last_rise = cyc;
    end
    if (ifc.ss_n && !prev_ss) ss_rise_cnt = ss_rise_cnt + 1;
    prev_sclk = ifc.sclk;
    prev_ss   = ifc.ss_n;
  end

  int n_cmp = 0, n_bad = 0;
  int b_rise, b_done, b_ren, b_wen, b_ovr, b_ss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_rise = rise_cnt; b_done = done_cnt; b_ren = ren_cnt;
    b_wen  = wen_cnt;  b_ovr  = ovr_cnt;  b_ss  = ss_rise_cnt;
  endtask

  task automatic push(input logic [31:0] d);
    tx_mem[tx_wr] = d;
    tx_wr = tx_wr + 3'd1;
  endtask

  task automatic set_cfg(input logic p, input logic h, input logic o,
                         input logic [4:0] len, input logic [7:0] div);
    ifc.cpol = p; ifc.cpha = h; ifc.dord = o; ifc.datalen = len; ifc.br_div = div;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (2) @(negedge pclk);
    while (ifc.busy && n < 2000) begin
      @(negedge pclk);
      n++;
    end
    chk({tag, "_idle"}, 32'(ifc.busy), 0);
    @(posedge pclk);
    #1;
  endtask

  initial begin
    int seen, falls, n, exp_ss;
    logic prev;
    for (int i = 0; i < 8; i++) tx_mem[i] = '0;
    preset_n = 1'b0;
    ifc.enable = 1'b0;
    ifc.rfifo_full = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0, 5'd7, 8'd1);
    repeat (3) @(negedge pclk);
    chk("rst_sclk", 32'(ifc.sclk), 0);
    chk("rst_ss_n", 32'(ifc.ss_n), 1);
    chk("rst_mosi", 32'(ifc.mosi), 0);
    chk("rst_ren", 32'(ifc.tfifo_ren), 0);
    chk("rst_wen", 32'(ifc.rfifo_wen), 0);
    chk("rst_wdata", ifc.rfifo_wdata, 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_done", 32'(ifc.done), 0);
    chk("rst_ovr", 32'(ifc.rx_overrun), 0);
    preset_n = 1'b1;
    repeat (2) @(negedge pclk);

    // Mode 0, MSB first, 8 bits, half-period 2 pclk
    snap();
    push(32'h0000_00A5);
    ifc.enable = 1'b1;
    wait_idle("t1");
    ifc.enable = 1'b0;
    chk("t1_rises", rise_cnt - b_rise, 8);
    chk("t1_mosi_seq", mosi_log & 32'hFF, 32'hA5);
    chk("t1_wdata", ifc.rfifo_wdata, 32'h0000_00A5);
    chk("t1_done", done_cnt - b_done, 1);
    chk("t1_ren", ren_cnt - b_ren, 1);
    chk("t1_wen", wen_cnt - b_wen, 1);
    chk("t1_ovr", ovr_cnt - b_ovr, 0);
    chk("t1_sclk_period", rise_per, 4);
    chk("t1_frame_time", store_cyc - load_cyc, 35);

    // Mode 3, LSB first, 4 bits
    set_cfg(1'b1, 1'b1, 1'b1, 5'd3, 8'd2);
    repeat (3) @(negedge pclk);
    chk("t2_sclk_idle_hi", 32'(ifc.sclk), 1);
    snap();
    push(32'h0000_000C);
    ifc.enable = 1'b1;
    wait_idle("t2");
    ifc.enable = 1'b0;
    chk("t2_rises", rise_cnt - b_rise, 4);
    chk("t2_mosi_seq", mosi_log & 32'hF, 32'h3);
    chk("t2_wdata", ifc.rfifo_wdata, 32'h0000_000C);
    chk("t2_frame_time", store_cyc - load_cyc, 28);
    chk("t2_sclk_end_hi", 32'(ifc.sclk), 1);

    // Full 32-bit frame at the fastest divider
    set_cfg(1'b0, 1'b0, 1'b0, 5'd31, 8'd0);
    snap();
    push(32'hDEAD_BEEF);
    ifc.enable = 1'b1;
    wait_idle("t3");
    ifc.enable = 1'b0;
    chk("t3_wdata", ifc.rfifo_wdata, 32'hDEAD_BEEF);
    chk("t3_mosi_seq", mosi_log, 32'hDEAD_BEEF);
    chk("t3_rises", rise_cnt - b_rise, 32);
    chk("t3_frame_time", store_cyc - load_cyc, 66);

    // RX FIFO full: frame dropped, then the next one goes through
    set_cfg(1'b0, 1'b1, 1'b0, 5'd4, 8'd0);
    ifc.rfifo_full = 1'b1;
    snap();
    push(32'hFFFF_FF73);
    ifc.enable = 1'b1;
    wait_idle("t4a");
    chk("t4_ovr_pulse", ovr_cnt - b_ovr, 1);
    chk("t4_done", done_cnt - b_done, 1);
    chk("t4_no_wen", wen_cnt - b_wen, 0);
    chk("t4_wdata_kept", ifc.rfifo_wdata, 32'hDEAD_BEEF);
    ifc.rfifo_full = 1'b0;
    snap();
    push(32'hFFFF_FF73);
    wait_idle("t4b");
    ifc.enable = 1'b0;
    chk("t4_next_wen", wen_cnt - b_wen, 1);
    chk("t4_next_wdata", ifc.rfifo_wdata, 32'h0000_0013);
    chk("t4_next_ovr", ovr_cnt - b_ovr, 0);

    // Three frames queued, enable dropped during frame 2
    set_cfg(1'b0, 1'b0, 1'b0, 5'd7, 8'd3);
    snap();
    push(32'h11); push(32'h22); push(32'h33);
    ifc.enable = 1'b1;
    seen = 0;
    n = 0;
    while (seen < 2 && n < 1000) begin
      @(negedge pclk);
      if (ifc.tfifo_ren) seen++;
      n++;
    end
    chk("t5_second_load", seen, 2);
    repeat (10) @(negedge pclk);
    ifc.enable = 1'b0;
    wait_idle("t5");
    chk("t5_ren", ren_cnt - b_ren, 2);
    chk("t5_done", done_cnt - b_done, 2);
    chk("t5_wen", wen_cnt - b_wen, 2);
    chk("t5_wdata", ifc.rfifo_wdata, 32'h22);
    chk("t5_fifo_left", 32'(3'(tx_wr - tx_rd)), 1);
`ifdef SPI_CONT_XFER_EN
    exp_ss = 1;
`else
    exp_ss = 2;
`endif
    chk("t5_ss_rises", ss_rise_cnt - b_ss, exp_ss);

    // Reset during TRAIL of bit 4 of frame 3
    snap();
    ifc.enable = 1'b1;
    falls = 0;
    n = 0;
    prev = ifc.sclk;
    while (falls < 5 && n < 1000) begin
      @(negedge pclk);
      if (prev && !ifc.sclk) falls++;
      prev = ifc.sclk;
      n++;
    end
    chk("t6_reached_bit4", falls, 5);
    preset_n = 1'b0;
    #1;
    chk("t6_sclk", 32'(ifc.sclk), 0);
    chk("t6_ss_n", 32'(ifc.ss_n), 1);
    chk("t6_mosi", 32'(ifc.mosi), 0);
    chk("t6_busy", 32'(ifc.busy), 0);
    chk("t6_wdata", ifc.rfifo_wdata, 0);
    chk("t6_done", 32'(ifc.done), 0);
    repeat (3) @(negedge pclk);
    preset_n = 1'b1;
    repeat (10) @(negedge pclk);
    chk("t6_stay_idle", 32'(ifc.busy), 0);
    chk("t6_no_wen", wen_cnt - b_wen, 0);
    chk("t6_no_pop", ren_cnt - b_ren, 1);
    push(32'h44);
    wait_idle("t6");
    ifc.enable = 1'b0;
    chk("t6_after_wdata", ifc.rfifo_wdata, 32'h44);
    chk("t6_after_wen", wen_cnt - b_wen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
